// File: rtl/crosscorr_div_pkg.sv
// Shared types and constants for the crosscorr sequential signed divider.
// The width constants here are the default values for the divider's width parameters.
package crosscorr_div_pkg;

  localparam int unsigned DIVIDEND_W = 50;
  localparam int unsigned DIVISOR_W  = 25;
  localparam int unsigned QUOTIENT_W = 25;
  localparam int unsigned CNT_W      = $clog2(DIVIDEND_W);

  // Saturation limits of the signed quotient
  localparam logic [QUOTIENT_W-1:0] QMAX = {1'b0, {(QUOTIENT_W-1){1'b1}}};
  localparam logic [QUOTIENT_W-1:0] QMIN = {1'b1, {(QUOTIENT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StCalc,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/crosscorr_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
// The caller keeps the partial remainder below dmag, so the borrow bit is a true sign.
module crosscorr_div_step #(
  parameter int unsigned W = 25
) (
  input  logic [W:0]   prem,
  input  logic         din,
  input  logic [W-1:0] dmag,
  output logic [W:0]   rem_next,
  output logic         qbit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  always_comb begin
    shifted  = {prem, din};
    diff     = shifted - {2'b00, dmag};
    qbit     = ~diff[W+1];
    rem_next = qbit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/crosscorr_sdiv_50s_25s_25_seq.sv
// Iterative signed divider with valid/ready handshakes, one quotient bit per cycle.
// Truncates toward zero, saturates the quotient and flags divide-by-zero.
module crosscorr_sdiv_50s_25s_25_seq
  import crosscorr_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int unsigned DIVISOR_WIDTH  = DIVISOR_W,
  parameter int unsigned QUOTIENT_WIDTH = QUOTIENT_W
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic signed [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [QUOTIENT_WIDTH-1:0] quotient,
  output logic signed [DIVISOR_WIDTH-1:0]  remainder,
  output logic                             div_by_zero,
  output logic                             overflow
);

  localparam int unsigned DW = DIVIDEND_WIDTH;
  localparam int unsigned VW = DIVISOR_WIDTH;
  localparam int unsigned QW = QUOTIENT_WIDTH;
  localparam int unsigned CW = $clog2(DIVIDEND_WIDTH);

  state_e        state_q, state_d;
  logic [DW-1:0] dvd_q;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] dvs_q;
  logic [VW:0]   rem_q;
  logic [CW-1:0] cnt_q;
  logic          sn_q, sd_q, zero_q;

  logic [VW:0]   rem_next;
  logic          qbit;
  logic          qneg;
  logic [DW-1:0] qlim;
  logic [QW-1:0] qlow;
  logic [VW-1:0] rmag;

  crosscorr_div_step #(
    .W (VW)
  ) u_step (
    .prem     (rem_q),
    .din      (dvd_q[DW-1]),
    .dmag     (dvs_q),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StPrep;
      StPrep:  state_d = StCalc;
      StCalc:  if (cnt_q == '0) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  // Negative quotients may reach one step further than positive ones
  always_comb begin
    qneg = sn_q ^ sd_q;
    qlim = qneg ? DW'(QMAX) + DW'(1) : DW'(QMAX);
    qlow = quo_q[QW-1:0];
    rmag = rem_q[VW-1:0];
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dvd_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      sn_q        <= 1'b0;
      sd_q        <= 1'b0;
      zero_q      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            sn_q  <= dividend[DW-1];
            sd_q  <= divisor[VW-1];
          end
        end
        StPrep: begin
          dvd_q  <= sn_q ? DW'(0) - dvd_q : dvd_q;
          dvs_q  <= sd_q ? VW'(0) - dvs_q : dvs_q;
          zero_q <= (dvs_q == '0);
          rem_q  <= '0;
          quo_q  <= '0;
          cnt_q  <= CW'(DW - 1);
        end
        StCalc: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[DW-2:0], qbit};
          dvd_q <= {dvd_q[DW-2:0], 1'b0};
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        StFix: begin
          if (zero_q) begin
            quotient    <= sn_q ? QMIN : QMAX;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            if (quo_q > qlim) quotient <= qneg ? QMIN : QMAX;
            else              quotient <= qneg ? QW'(0) - qlow : qlow;
            remainder   <= sn_q ? VW'(0) - rmag : rmag;
            div_by_zero <= 1'b0;
            overflow    <= (quo_q > qlim);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/crosscorr_sdiv_50s_25s_25_seq.md
Name: crosscorr_sdiv_50s_25s_25_seq

Overview:
- Iterative signed divider: the inverse of the 25x25->50 signed product path in the crosscorr datapath.
- Renormalises accumulated 50-bit cross-power products by a 25-bit magnitude term (GCC-PHAT weighting), returning a 25-bit quotient and remainder.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Valid/ready handshake on both sides so it can be dropped between HLS-generated stages.

Parameters:
- DIVIDEND_WIDTH, 50: signed dividend width; also the CALC iteration count.
- DIVISOR_WIDTH, 25: signed divisor width.
- QUOTIENT_WIDTH, 25: signed quotient width (saturating).
- Remainder width is fixed equal to DIVISOR_WIDTH.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  DIVIDEND_WIDTH  signed numerator.
- divisor  in  DIVISOR_WIDTH  signed denominator.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- quotient  out  QUOTIENT_WIDTH  signed quotient, truncated toward zero, saturated.
- remainder  out  DIVISOR_WIDTH  signed remainder; sign follows dividend.
- div_by_zero  out  1  divisor was 0 for this result.
- overflow  out  1  true quotient did not fit QUOTIENT_WIDTH; quotient saturated.

Behaviour:
- Reset state: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, all internal registers cleared.
- Reset is asynchronous and aborts any operation immediately; no result is emitted for an aborted job.
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register operands and both sign bits; go to PREP.
- PREP (1 cycle):
  - Form magnitudes |dividend| (DIVIDEND_WIDTH-bit unsigned; the most negative value maps to 2^(W-1) exactly) and |divisor|.
  - Set the zero flag if divisor==0.
  - Clear the partial remainder (DIVISOR_WIDTH+1 bits); load the iteration counter with DIVIDEND_WIDTH-1.
- CALC (DIVIDEND_WIDTH cycles):
  - Shift the next dividend MSB into the partial remainder.
  - Trial-subtract |divisor|. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set 0.
  - Decrement the counter; leave CALC after the count-0 iteration.
  - The counter must not wrap.
- FIX (1 cycle):
  - Quotient sign = sign(dividend) XOR sign(divisor). Remainder sign = sign(dividend); negate the magnitude if required.
  - Range check on the DIVIDEND_WIDTH-bit quotient magnitude: positive results must be <= 2^(Q-1)-1; negative results must be <= 2^(Q-1).
  - Out of range: saturate to 2^(Q-1)-1 or -2^(Q-1) and set overflow=1.
  - Divisor zero: quotient = +max if dividend >= 0, else -min; remainder = 0; div_by_zero=1; overflow=0.
  - Register the outputs, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1. quotient, remainder and flags are held stable until out_ready.
  - On out_ready: clear out_valid, go to IDLE.
- in_ready=1 only in IDLE; new inputs are ignored in every other state.
- Latency is fixed, including the divide-by-zero case: operands accepted at edge k give out_valid=1 after edge k+DIVIDEND_WIDTH+2 (52 cycles by default).
- Throughput with out_ready tied high: one result per DIVIDEND_WIDTH+4 cycles.
- Output registers change only when entering DONE; they keep their values after the handshake until the next FIX.
- Arithmetic: all magnitudes are unsigned. A single DIVISOR_WIDTH+1-bit subtractor is the only adder in CALC. No multiplier or DSP inference.

Decomposition:
- Package crosscorr_div_pkg:
  - state enum (IDLE, PREP, CALC, FIX, DONE);
  - width localparams;
  - QMAX/QMIN saturation constants;
  - iteration-counter width = clog2(DIVIDEND_WIDTH).
- One sub-module, crosscorr_div_step: combinational restoring step.
  - Inputs: partial remainder, incoming bit, |divisor|.
  - Outputs: next remainder, quotient bit.
  - Reusable for a future unrolled/pipelined variant.

Test Plan:
- 100 / 7 -> quotient=14, remainder=2, flags 0; out_valid exactly 52 cycles after acceptance.
- -100 / 7 -> q=-14, r=-2. 100 / -7 -> q=-14, r=2. -100 / -7 -> q=14, r=-2.
- 5 / 0 -> q=16777215, r=0, div_by_zero=1. -5 / 0 -> q=-16777216, div_by_zero=1. Latency is still 52.
- Range boundaries:
  - 2^40 / 1 -> q=16777215, overflow=1.
  - -2^24 / 1 -> q=-16777216, overflow=0.
  - -2^49 / -1 -> q=16777215, overflow=1.
  - 2^24 / 1 -> q=16777215, overflow=1.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid. Outputs stay stable, in_ready=0, and an in_valid pulse during the stall is ignored.
  - Release out_ready: IDLE on the next cycle, then the next job is accepted.
- Reset mid-operation:
  - Assert ap_rst asynchronously mid-CALC (cycle 20). Outputs are immediately 0, in_ready=1, and no out_valid is emitted.
  - A following 1000 / 3 -> q=333, r=1.
